dbg_trace_gen: RTL and testbench

Trace producer for the pipelined ZPU core. It pairs instruction-retire events (PC, opcode, SP) with the stack-top values (TOS, NOS) that the stack cache resolves later, possibly several cycles afterwards. It emits one 137-bit registered debug record per retired instruction on `dbg_o`, using the layout that the testbench trace logger consumes. A small in-order pending FIFO decouples the two sources, and the block back-pressures retire when that FIFO is full.

---
 rtl/dbg_trace_gen.sv | 71 +++++++
 tb/tb_dbg_trace_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dbg_trace_gen.sv
// dbg_trace_gen: pairs ZPU retire events with late stack-top values into 137-bit trace records
// Ports: clk, rst (async, active-high); trace_en enables the block, low flushes it;
//        ret_valid/ret_pc/ret_inst/ret_sp retire event, ret_stall holds retire while the FIFO is full;
//        stk_valid/stk_tos/stk_nos stack-top values for the oldest pending retire;
//        dbg_o record {valid, inst, nos, tos, sp, pc}; rec_cnt records since reset/enable;
//        err sticky flag for stk_valid with nothing to pair.
module dbg_trace_gen #(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         trace_en,
   input  logic         ret_valid,
   input  logic [31:0]  ret_pc,
   input  logic [7:0]   ret_inst,
   input  logic [31:0]  ret_sp,
   output logic         ret_stall,
   input  logic         stk_valid,
   input  logic [31:0]  stk_tos,
   input  logic [31:0]  stk_nos,
   output logic [136:0] dbg_o,
   output logic [31:0]  rec_cnt,
   output logic         err
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   logic [71:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic full, empty, push, pop, byp, orphan, emit;
   logic [71:0] head;
   always_comb begin
      full      = cnt == CNT_FULL;
      empty     = cnt == '0;
      ret_stall = trace_en & full;
      // a same-cycle retire on an empty FIFO is paired directly and never stored
      push      = trace_en & ret_valid & ~full & ~(empty & stk_valid);
      pop       = trace_en & stk_valid & ~empty;
      byp       = trace_en & stk_valid & empty & ret_valid;
      orphan    = trace_en & stk_valid & empty & ~ret_valid;
      emit      = pop | byp;
      head      = pop ? mem[rp] : {ret_inst, ret_sp, ret_pc};
   end
   always_ff @(posedge clk)
      if (push) mem[wp] <= {ret_inst, ret_sp, ret_pc};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp      <= '0;
         rp      <= '0;
         cnt     <= '0;
         dbg_o   <= '0;
         rec_cnt <= '0;
         err     <= 1'b0;
      end else if (!trace_en) begin
         wp         <= '0;
         rp         <= '0;
         cnt        <= '0;
         dbg_o[136] <= 1'b0;
         rec_cnt    <= '0;
         err        <= 1'b0;
      end else begin
         wp      <= push ? wp + PTR_ONE : wp;
         rp      <= pop ? rp + PTR_ONE : rp;
         cnt     <= (push & ~pop) ? cnt + CNT_ONE : (pop & ~push) ? cnt - CNT_ONE : cnt;
         dbg_o   <= emit ? {1'b1, head[71:64], stk_nos, stk_tos, head[63:0]} : {1'b0, dbg_o[135:0]};
         rec_cnt <= emit ? rec_cnt + 32'd1 : rec_cnt;
         err     <= err | orphan;
      end
endmodule

// File: tb/tb_dbg_trace_gen.sv
// tb_dbg_trace_gen: scoreboard bench for dbg_trace_gen
module tb_dbg_trace_gen;
   localparam int DEPTH = 4;
   logic clk = 0, rst = 1, trace_en = 1, ret_valid = 0, stk_valid = 0;
   logic [31:0] ret_pc = 0, ret_sp = 0, stk_tos = 0, stk_nos = 0;
   logic [7:0] ret_inst = 0;
   logic ret_stall, err;
   logic [136:0] dbg_o, mon_e, held;
   logic [31:0] rec_cnt;
   int checks = 0, failures = 0;
   int rec_model = 0, pop_cnt = 0;
   logic err_model = 0;
   logic [71:0] pend_q[$];
   logic [136:0] exp_q[$];

   always #5 clk = ~clk;

   dbg_trace_gen #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .trace_en(trace_en),
      .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst), .ret_sp(ret_sp), .ret_stall(ret_stall),
      .stk_valid(stk_valid), .stk_tos(stk_tos), .stk_nos(stk_nos),
      .dbg_o(dbg_o), .rec_cnt(rec_cnt), .err(err)
   );

   always @(negedge clk)
      if (dbg_o[136]) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL record_unexpected got=%h", dbg_o);
         end else begin
            mon_e = exp_q.pop_front();
            pop_cnt++;
            if (dbg_o !== mon_e) begin
               failures++;
               $display("FAIL record got=%h exp=%h", dbg_o, mon_e);
            end
         end
      end

   // drives one cycle of stimulus and updates the pairing model; returns 1ns after the edge
   task automatic step(input logic rv, input logic [31:0] pc, input logic [7:0] inst, input logic [31:0] sp,
                       input logic sv, input logic [31:0] tos, input logic [31:0] nos);
      int n;
      logic [71:0] h;
      ret_valid = rv; ret_pc = pc; ret_inst = inst; ret_sp = sp;
      stk_valid = sv; stk_tos = tos; stk_nos = nos;
      n = pend_q.size();
      if (!trace_en) begin
         pend_q.delete(); rec_model = 0; err_model = 0;
      end else if (sv && n == 0) begin
         if (rv) begin
            exp_q.push_back({1'b1, inst, nos, tos, sp, pc}); rec_model++;
         end else err_model = 1;
      end else begin
         if (sv) begin
            h = pend_q.pop_front();
            exp_q.push_back({1'b1, h[71:64], nos, tos, h[63:0]}); rec_model++;
         end
         if (rv && n < DEPTH) pend_q.push_back({inst, sp, pc});
      end
      @(posedge clk); #1;
      ret_valid = 0; stk_valid = 0;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (dbg_o !== '0) begin failures++; $display("FAIL reset_dbg got=%h exp=0", dbg_o); end
      checks++; if (rec_cnt !== 0) begin failures++; $display("FAIL reset_rec_cnt got=%0d exp=0", rec_cnt); end
      checks++; if (err !== 0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (ret_stall !== 0) begin failures++; $display("FAIL reset_stall got=%b exp=0", ret_stall); end
      rst = 0;
   endtask

   task automatic test_bypass();
      step(1, 32'h100, 8'h8A, 32'h7FF8, 1, 32'd5, 32'd9);
      checks++; if (dbg_o !== {1'b1, 8'h8A, 32'd9, 32'd5, 32'h7FF8, 32'h100}) begin failures++; $display("FAIL bypass_rec got=%h", dbg_o); end
      checks++; if (rec_cnt !== 32'd1) begin failures++; $display("FAIL bypass_rec_cnt got=%0d exp=1", rec_cnt); end
      held = dbg_o;
      idle();
      checks++; if (dbg_o !== {1'b0, held[135:0]}) begin failures++; $display("FAIL bypass_hold got=%h exp=%h", dbg_o, {1'b0, held[135:0]}); end
   endtask

   task automatic test_deferred();
      for (int i = 0; i < 3; i++) step(1, 32'h10 + i, 8'(8'h20 + i), 32'h7000 - 4 * i, 0, 0, 0);
      repeat (5) idle();
      checks++; if (dbg_o[136] !== 0) begin failures++; $display("FAIL deferred_early got=%b exp=0", dbg_o[136]); end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 1, 32'hA0 + i, 32'hB0 + i);
         checks++; if (dbg_o[136] !== 1 || dbg_o[31:0] !== 32'h10 + i) begin failures++; $display("FAIL deferred_pc got=%h exp=%h", dbg_o[31:0], 32'h10 + i); end
         idle();
         checks++; if (dbg_o[136] !== 0) begin failures++; $display("FAIL deferred_gap got=%b exp=0", dbg_o[136]); end
      end
      checks++; if (rec_cnt !== rec_model) begin failures++; $display("FAIL deferred_rec_cnt got=%0d exp=%0d", rec_cnt, rec_model); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) step(1, 32'h20 + i, 8'h01, 32'h6000, 0, 0, 0);
      checks++; if (ret_stall !== 1) begin failures++; $display("FAIL full_stall got=%b exp=1", ret_stall); end
      step(1, 32'h24, 8'h01, 32'h6000, 0, 0, 0);
      checks++; if (ret_stall !== 1) begin failures++; $display("FAIL full_stall_hold got=%b exp=1", ret_stall); end
      step(0, 0, 0, 0, 1, 32'h1, 32'h2);
      checks++; if (dbg_o[31:0] !== 32'h20) begin failures++; $display("FAIL full_pop_pc got=%h exp=20", dbg_o[31:0]); end
      checks++; if (ret_stall !== 0) begin failures++; $display("FAIL full_stall_drop got=%b exp=0", ret_stall); end
      step(1, 32'h25, 8'h02, 32'h6004, 0, 0, 0);
      checks++; if (ret_stall !== 1) begin failures++; $display("FAIL full_refill got=%b exp=1", ret_stall); end
      step(1, 32'h26, 8'h03, 32'h6008, 1, 32'h3, 32'h4);
      checks++; if (dbg_o[31:0] !== 32'h21) begin failures++; $display("FAIL full_pushpop_pc got=%h exp=21", dbg_o[31:0]); end
      checks++; if (ret_stall !== 0) begin failures++; $display("FAIL full_pushpop_stall got=%b exp=0", ret_stall); end
      repeat (3) step(0, 0, 0, 0, 1, $urandom, $urandom);
      idle();
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_missing got=%0d exp=0", exp_q.size()); end
      checks++; if (err !== 0) begin failures++; $display("FAIL full_err got=%b exp=0", err); end
   endtask

   task automatic test_orphan();
      step(0, 0, 0, 0, 1, 32'h7, 32'h8);
      checks++; if (err !== 1) begin failures++; $display("FAIL orphan_err got=%b exp=1", err); end
      checks++; if (dbg_o[136] !== 0) begin failures++; $display("FAIL orphan_rec got=%b exp=0", dbg_o[136]); end
      repeat (3) idle();
      checks++; if (err !== 1) begin failures++; $display("FAIL orphan_sticky got=%b exp=1", err); end
      trace_en = 0;
      idle();
      trace_en = 1;
      checks++; if (err !== 0) begin failures++; $display("FAIL orphan_clear got=%b exp=0", err); end
      checks++; if (rec_cnt !== 0) begin failures++; $display("FAIL orphan_rec_cnt got=%0d exp=0", rec_cnt); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) step(1, 32'h30 + i, 8'h05, 32'h5000, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'h11, 32'h12);
      trace_en = 0;
      idle();
      trace_en = 1;
      checks++; if (dbg_o[136] !== 0) begin failures++; $display("FAIL flush_valid got=%b exp=0", dbg_o[136]); end
      checks++; if (rec_cnt !== 0) begin failures++; $display("FAIL flush_rec_cnt got=%0d exp=0", rec_cnt); end
      step(0, 0, 0, 0, 1, 32'h13, 32'h14);
      checks++; if (err !== 1) begin failures++; $display("FAIL flush_empty_err got=%b exp=1", err); end
      checks++; if (dbg_o[136] !== 0) begin failures++; $display("FAIL flush_no_rec got=%b exp=0", dbg_o[136]); end
      trace_en = 0;
      idle();
      trace_en = 1;
   endtask

   task automatic test_async_rst();
      step(1, 32'h40, 8'h06, 32'h4000, 0, 0, 0);
      step(1, 32'h41, 8'h06, 32'h4000, 1, 32'h21, 32'h22);
      checks++; if (dbg_o[136] !== 1) begin failures++; $display("FAIL arst_pre got=%b exp=1", dbg_o[136]); end
      rst = 1;
      #1;
      checks++; if (dbg_o !== '0) begin failures++; $display("FAIL arst_dbg got=%h exp=0", dbg_o); end
      checks++; if (rec_cnt !== 0) begin failures++; $display("FAIL arst_rec_cnt got=%0d exp=0", rec_cnt); end
      exp_q.delete(); pend_q.delete(); rec_model = 0; err_model = 0;
      @(posedge clk); #1;
      rst = 0;
      checks++; if (ret_stall !== 0) begin failures++; $display("FAIL arst_stall got=%b exp=0", ret_stall); end
   endtask

   task automatic test_stress();
      logic rv, sv;
      trace_en = 0;
      idle();
      trace_en = 1;
      pop_cnt = 0;
      for (int c = 0; c < 10000; c++) begin
         checks++; if (ret_stall !== (pend_q.size() == DEPTH)) begin failures++; $display("FAIL stress_stall cyc=%0d got=%b exp=%b", c, ret_stall, pend_q.size() == DEPTH); end
         rv = ($urandom_range(0, 99) < 60) && (pend_q.size() < DEPTH);
         sv = ($urandom_range(0, 99) < 55) && (pend_q.size() > 0 || rv);
         step(rv, $urandom, 8'($urandom), $urandom, sv, $urandom, $urandom);
      end
      for (int i = 0; i < DEPTH && pend_q.size() > 0; i++) step(0, 0, 0, 0, 1, $urandom, $urandom);
      idle();
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stress_missing got=%0d exp=0", exp_q.size()); end
      checks++; if (err !== err_model) begin failures++; $display("FAIL stress_err got=%b exp=%b", err, err_model); end
      checks++; if (rec_cnt !== pop_cnt) begin failures++; $display("FAIL stress_rec_cnt got=%0d exp=%0d", rec_cnt, pop_cnt); end
      checks++; if (rec_cnt !== rec_model) begin failures++; $display("FAIL stress_rec_model got=%0d exp=%0d", rec_cnt, rec_model); end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_deferred();
      test_full();
      test_orphan();
      test_flush();
      test_async_rst();
      test_stress();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
